// File: rtl/lane_packer_if.sv
// lane_packer_if: ready/valid bus for lane_packer.
//   in_valid/in_ready  : sparse input beat handshake
//   in_data/in_mask    : LANES lanes of DATA_W bits plus per-lane valid mask
//   in_last            : end of packet, flush everything held
//   out_valid/out_ready: packed output word handshake
//   out_data/out_count : packed entries (entry 0 oldest) and number of valid entries
//   out_last           : last word of the packet
// master = beat producer / word consumer, slave = the packer.
interface lane_packer_if #(
  parameter int LANES  = 16,
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(LANES + 1)
);
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_data;
  logic [LANES-1:0]        in_mask;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*DATA_W-1:0] out_data;
  logic [CNT_W-1:0]        out_count;
  logic                    out_last;

  modport master (
    output in_valid, in_data, in_mask, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_last
  );

  modport slave (
    input  in_valid, in_data, in_mask, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_last
  );
endinterface

// File: rtl/lane_packer.sv
// lane_packer: compacts masked input lanes (lowest index first), appends them
// to residue held from earlier beats and emits dense LANES-entry words through
// a registered output stage. in_last flushes the residue as a partial word.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - lane_packer_if slave modport (input beats, output words)
module lane_packer #(
  parameter int LANES  = 16,
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(LANES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  lane_packer_if.slave  bus
);

  localparam int SLOTS = 2 * LANES - 1;
  localparam int TOT_W = $clog2(2 * LANES);
  localparam logic [TOT_W-1:0] LANES_T = TOT_W'(LANES);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                  state, state_next;
  logic [DATA_W-1:0]       res_q [LANES-1];
  logic [CNT_W-1:0]        res_cnt;
  logic [DATA_W-1:0]       res_d [LANES-1];
  logic [CNT_W-1:0]        res_cnt_d;

  logic                    out_valid_q;
  logic [LANES*DATA_W-1:0] out_data_q;
  logic [CNT_W-1:0]        out_count_q;
  logic                    out_last_q;

  logic [DATA_W-1:0]       stream [SLOTS];
  logic [TOT_W-1:0]        total;
  logic                    slot_free;
  logic                    in_ready;
  logic                    accept;

  logic                    load;
  logic [LANES*DATA_W-1:0] load_data;
  logic [CNT_W-1:0]        load_count;
  logic                    load_last;

  assign slot_free = !out_valid_q || bus.out_ready;
  assign accept    = bus.in_valid && in_ready;

  // Stream = residue then masked lanes; slots past total stay zero, which
  // gives the zero padding of partial words and residue for free.
  always_comb begin
    for (int unsigned j = 0; j < SLOTS; j++) stream[j] = '0;
    for (int unsigned j = 0; j < LANES - 1; j++)
      if (CNT_W'(j) < res_cnt) stream[j] = res_q[j];
    total = TOT_W'(res_cnt);
    for (int unsigned i = 0; i < LANES; i++) begin
      if (bus.in_mask[i]) begin
        stream[total] = bus.in_data[i*DATA_W +: DATA_W];
        total = total + 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      RUN:   if (accept && bus.in_last && total > LANES_T) state_next = FLUSH;
      FLUSH: if (slot_free) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = (state == RUN) && slot_free && !rst;
  end

  // Datapath control: what to load into the output register and residue
  always_comb begin
    load       = 1'b0;
    load_data  = '0;
    load_count = '0;
    load_last  = 1'b0;
    res_d      = res_q;
    res_cnt_d  = res_cnt;
    if (state == FLUSH) begin
      if (slot_free) begin
        load = 1'b1;
        for (int unsigned j = 0; j < LANES - 1; j++)
          if (CNT_W'(j) < res_cnt) load_data[j*DATA_W +: DATA_W] = res_q[j];
        load_count = res_cnt;
        load_last  = 1'b1;
        res_cnt_d  = '0;
        for (int unsigned j = 0; j < LANES - 1; j++) res_d[j] = '0;
      end
    end else if (accept) begin
      if (total >= LANES_T) begin
        load = 1'b1;
        for (int unsigned j = 0; j < LANES; j++) load_data[j*DATA_W +: DATA_W] = stream[j];
        load_count = CNT_W'(LANES);
        load_last  = bus.in_last && (total == LANES_T);
        for (int unsigned j = 0; j < LANES - 1; j++) res_d[j] = stream[j + LANES];
        res_cnt_d = CNT_W'(total - LANES_T);
      end else if (bus.in_last) begin
        load = 1'b1;
        for (int unsigned j = 0; j < LANES; j++) load_data[j*DATA_W +: DATA_W] = stream[j];
        load_count = CNT_W'(total);
        load_last  = 1'b1;
        res_cnt_d  = '0;
        for (int unsigned j = 0; j < LANES - 1; j++) res_d[j] = '0;
      end else begin
        for (int unsigned j = 0; j < LANES - 1; j++) res_d[j] = stream[j];
        res_cnt_d = CNT_W'(total);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_last_q  <= 1'b0;
      res_cnt     <= '0;
      for (int unsigned j = 0; j < LANES - 1; j++) res_q[j] <= '0;
    end else begin
      if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= load_data;
        out_count_q <= load_count;
        out_last_q  <= load_last;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      res_cnt <= res_cnt_d;
      for (int unsigned j = 0; j < LANES - 1; j++) res_q[j] <= res_d[j];
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_lane_packer.sv
module tb_lane_packer;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  lane_packer_if #(.LANES(4), .DATA_W(8)) bus ();

  lane_packer #(.LANES(4), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mask;
    logic [7:0]  base;
    logic        last;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [2:0]  exp_count;
    logic        exp_last;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [31:0] lanes(input logic [7:0] b);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] d, input logic [2:0] c,
                            input logic l);
    check({name, ".valid"}, 32'(bus.out_valid), 32'd1);
    check({name, ".data"},  bus.out_data, d);
    check({name, ".count"}, 32'(bus.out_count), 32'(c));
    check({name, ".last"},  32'(bus.out_last), 32'(l));
  endtask

  // Present a beat, wait (bounded) for in_ready, return #1 after the accepting edge.
  task automatic send_beat(input logic [3:0] m, input logic [31:0] d, input logic l);
    int unsigned n;
    n = 0;
    bus.in_mask  = m;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stuck at 0, required 1");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  logic [31:0] hold_data;
  logic [2:0]  hold_count;
  logic        hold_last;

  initial begin
    tests = 0;
    fails = 0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mask   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;

    //          mask     base   last exp_v exp_data        cnt  last
    vecs[0] = '{4'b1111, 8'h10, 1'b0, 1'b1, 32'h13121110, 3'd4, 1'b0};
    vecs[1] = '{4'b0101, 8'hA0, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0};
    vecs[2] = '{4'b1110, 8'hB0, 1'b0, 1'b1, 32'hB2B1A2A0, 3'd4, 1'b0};
    vecs[3] = '{4'b0000, 8'hF0, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0};
    vecs[4] = '{4'b1001, 8'hC0, 1'b1, 1'b1, 32'h00C3C0B3, 3'd3, 1'b1};
    vecs[5] = '{4'b0000, 8'hF0, 1'b1, 1'b1, 32'h00000000, 3'd0, 1'b1};
    vecs[6] = '{4'b0011, 8'hD0, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0};
    vecs[7] = '{4'b0110, 8'hE0, 1'b0, 1'b1, 32'hE2E1D1D0, 3'd4, 1'b0};
    vecs[8] = '{4'b1111, 8'h10, 1'b1, 1'b1, 32'h13121110, 3'd4, 1'b1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset.out_valid", 32'(bus.out_valid), 32'd0);
    check("reset.out_data",  bus.out_data, 32'd0);
    check("reset.out_count", 32'(bus.out_count), 32'd0);
    check("reset.out_last",  32'(bus.out_last), 32'd0);

    for (int i = 0; i < 9; i++) begin
      send_beat(vecs[i].mask, lanes(vecs[i].base), vecs[i].last);
      if (vecs[i].exp_valid)
        check_word($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_count, vecs[i].exp_last);
      else
        check($sformatf("vec%0d.valid", i), 32'(bus.out_valid), 32'd0);
    end

    // Overflowing last beat: residue {20,21,22} + four lanes with last
    send_beat(4'b0111, lanes(8'h20), 1'b0);
    check("ovf.res_only.valid", 32'(bus.out_valid), 32'd0);
    send_beat(4'b1111, lanes(8'h10), 1'b1);
    check_word("ovf.word1", 32'h10222120, 3'd4, 1'b0);
    @(negedge clk);
    check("ovf.flush_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    check_word("ovf.word2", 32'h00131211, 3'd3, 1'b1);
    @(negedge clk);
    check("ovf.after_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Backpressure: hold out_ready low with a beat waiting
    bus.out_ready = 1'b0;
    send_beat(4'b1111, lanes(8'h30), 1'b0);
    check_word("bp.first", 32'h33323130, 3'd4, 1'b0);
    hold_data  = bus.out_data;
    hold_count = bus.out_count;
    hold_last  = bus.out_last;
    bus.in_mask  = 4'b1111;
    bus.in_data  = lanes(8'h40);
    bus.in_last  = 1'b0;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp.in_ready%0d", c), 32'(bus.in_ready), 32'd0);
      check($sformatf("bp.stable%0d", c),
            {bus.out_data[23:0], 3'(bus.out_count), bus.out_last, 3'b0, bus.out_valid},
            {hold_data[23:0], hold_count, hold_last, 3'b0, 1'b1});
      check($sformatf("bp.msb%0d", c), 32'(bus.out_data[31:24]), 32'(hold_data[31:24]));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check_word("bp.second", 32'h43424140, 3'd4, 1'b0);
    @(posedge clk);
    #1;
    check("bp.drained", 32'(bus.out_valid), 32'd0);

    // Reset mid-packet with residue 2 and a pending word
    send_beat(4'b0011, lanes(8'h50), 1'b0);
    bus.out_ready = 1'b0;
    send_beat(4'b1111, lanes(8'h60), 1'b0);
    check_word("rst.pending", 32'h61605150, 3'd4, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("rst.in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.out_data",  bus.out_data, 32'd0);
    check("rst.out_count", 32'(bus.out_count), 32'd0);
    check("rst.out_last",  32'(bus.out_last), 32'd0);
    bus.out_ready = 1'b1;
    send_beat(4'b1111, lanes(8'h70), 1'b0);
    check_word("rst.next", 32'h73727170, 3'd4, 1'b0);
    send_beat(4'b0000, lanes(8'h80), 1'b1);
    check_word("rst.empty_last", 32'h00000000, 3'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
